tea_operand_loader: RTL and testbench

Front-end stage that assembles the six 32-bit TEA operands (v0, v1, k0, k1, k2, k3) from byte-wide switch entries, one byte per press of the go button. It sits directly upstream of the encrypt/decrypt datapath. The operands are presented in parallel with a valid/ready handshake, which replaces the current 10-bit-per-operand load states. It owns input synchronisation and, optionally, debouncing of the go button.

---
 rtl/tea_pkg.sv | 28 ++
 rtl/go_conditioner.sv | 60 ++++++
 rtl/tea_operand_loader.sv | 113 +++++++++++
 tb/tb_tea_operand_loader.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/tea_pkg.sv
// Shared TEA definitions: loader FSM states, operand geometry, word indices and key schedule constant.
// Imported by the operand loader and the encrypt/decrypt datapath.
package tea_pkg;

  typedef enum logic [1:0] {
    ST_COLLECT      = 2'd0,
    ST_WAIT_RELEASE = 2'd1,
    ST_PRESENT      = 2'd2
  } state_t;

  localparam int WORDS          = 6;
  localparam int BYTES_PER_WORD = 4;

  localparam logic [2:0] W_V0 = 3'd0;
  localparam logic [2:0] W_V1 = 3'd1;
  localparam logic [2:0] W_K0 = 3'd2;
  localparam logic [2:0] W_K1 = 3'd3;
  localparam logic [2:0] W_K2 = 3'd4;
  localparam logic [2:0] W_K3 = 3'd5;

  localparam logic [31:0] TEA_DELTA = 32'h9E3779B9;

  // Bytes fill MSB first, so entry n of a word lands in lane (3 - n).
  function automatic logic [4:0] lane_lsb(input logic [1:0] byte_idx);
    return {~byte_idx, 3'b000};
  endfunction

endpackage

// File: rtl/go_conditioner.sv
// go button conditioning: 2-flop synchroniser, optional debounce (LOADER_DEBOUNCE_EN), press/release pulses.
// Latency: 2 cycles to press/release, plus DEBOUNCE_CYCLES when filtered; no backpressure.
module go_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic resetn,
  input  logic go,
  output logic press,
  output logic rel
);

  logic sync1, sync2;
  logic go_f, go_f_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= go;
      sync2 <= sync1;
    end
  end

`ifdef LOADER_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] cnt;
  logic          go_f_r;

  // The filtered level only follows sync2 after it has disagreed for DEBOUNCE_CYCLES in a row.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt    <= '0;
      go_f_r <= 1'b0;
    end else if (sync2 == go_f_r) begin
      cnt <= '0;
    end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      go_f_r <= sync2;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign go_f = go_f_r;
`else
  assign go_f = sync2;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) go_f_q <= 1'b0;
    else         go_f_q <= go_f;
  end

  assign press = go_f & ~go_f_q;
  assign rel   = ~go_f & go_f_q;

endmodule

// File: rtl/tea_operand_loader.sv
// Assembles v0,v1,k0..k3 from byte-wide entries, one byte per go press (debounce via LOADER_DEBOUNCE_EN).
// Latency: out_valid 1 cycle after the 24th release; holds operands stable until out_valid && out_ready.
import tea_pkg::*;

module tea_operand_loader #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        go,
  input  logic [7:0]  data_in,
  input  logic        abort,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] v0,
  output logic [31:0] v1,
  output logic [31:0] k0,
  output logic [31:0] k1,
  output logic [31:0] k2,
  output logic [31:0] k3,
  output logic [2:0]  word_idx,
  output logic [1:0]  byte_idx
);

  state_t      state, state_nxt;
  logic [31:0] ops [WORDS];
  logic        press, rel;
  logic        last_byte, last_word;
  logic        capture, advance, clear_idx;

  go_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_go_cond (
    .clk    (clk),
    .resetn (resetn),
    .go     (go),
    .press  (press),
    .rel    (rel)
  );

  assign last_byte = (byte_idx == 2'(BYTES_PER_WORD - 1));
  assign last_word = (word_idx == 3'(WORDS - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_COLLECT;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = ST_COLLECT;
    end else begin
      case (state)
        ST_COLLECT:      if (press) state_nxt = ST_WAIT_RELEASE;
        ST_WAIT_RELEASE: if (rel)   state_nxt = (last_byte && last_word) ? ST_PRESENT : ST_COLLECT;
        ST_PRESENT:      if (out_ready) state_nxt = ST_COLLECT;
        default:         state_nxt = ST_COLLECT;
      endcase
    end
  end

  // out_valid is a pure state decode, so out_ready never reaches it combinationally.
  always_comb begin
    out_valid = 1'b0;
    capture   = 1'b0;
    advance   = 1'b0;
    clear_idx = 1'b0;
    case (state)
      ST_COLLECT:      capture   = press;
      ST_WAIT_RELEASE: advance   = rel && !(last_byte && last_word);
      ST_PRESENT: begin
        out_valid = 1'b1;
        clear_idx = out_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      word_idx <= '0;
      byte_idx <= '0;
      for (int i = 0; i < WORDS; i++) ops[i] <= '0;
    end else if (abort) begin
      word_idx <= '0;
      byte_idx <= '0;
      for (int i = 0; i < WORDS; i++) ops[i] <= '0;
    end else begin
      if (capture) ops[word_idx][lane_lsb(byte_idx) +: 8] <= data_in;
      if (advance) begin
        if (last_byte) begin
          byte_idx <= '0;
          word_idx <= word_idx + 3'd1;
        end else begin
          byte_idx <= byte_idx + 2'd1;
        end
      end
      if (clear_idx) begin
        word_idx <= '0;
        byte_idx <= '0;
      end
    end
  end

  assign v0 = ops[W_V0];
  assign v1 = ops[W_V1];
  assign k0 = ops[W_K0];
  assign k1 = ops[W_K1];
  assign k2 = ops[W_K2];
  assign k3 = ops[W_K3];

endmodule

// File: tb/tb_tea_operand_loader.sv
// Directed/random bench for tea_operand_loader; expected operands come from a byte-list model.
module tb_tea_operand_loader;

`ifdef LOADER_DEBOUNCE_EN
  localparam int HOLD = 14;
  localparam int PDET = 10;
`else
  localparam int HOLD = 4;
  localparam int PDET = 2;
`endif

  logic        clk = 1'b0;
  logic        resetn, go, abort, out_ready;
  logic [7:0]  data_in;
  logic        out_valid;
  logic [31:0] v0, v1, k0, k1, k2, k3;
  logic [2:0]  word_idx;
  logic [1:0]  byte_idx;
  logic [191:0] ops_now;

  int n_checks = 0;
  int n_pass   = 0;
  int valid_cycles = 0;
  int unstable_cnt = 0;
  logic         valid_q = 1'b0;
  logic [191:0] ops_hold = '0;
  logic [7:0]   bytes [24];

  tea_operand_loader #(.DEBOUNCE_CYCLES(8)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .go        (go),
    .data_in   (data_in),
    .abort     (abort),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .v0        (v0),
    .v1        (v1),
    .k0        (k0),
    .k1        (k1),
    .k2        (k2),
    .k3        (k3),
    .word_idx  (word_idx),
    .byte_idx  (byte_idx)
  );

  assign ops_now = {v0, v1, k0, k1, k2, k3};

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_valid) begin
      valid_cycles++;
      if (valid_q && ops_now !== ops_hold) unstable_cnt++;
    end
    valid_q  = out_valid;
    ops_hold = ops_now;
  end

  // Operand words are the byte list read four at a time, first byte most significant.
  function automatic logic [191:0] model(input logic [7:0] b [24]);
    logic [191:0] r;
    r = '0;
    for (int w = 0; w < 6; w++)
      r[191 - 32*w -: 32] = {b[4*w], b[4*w+1], b[4*w+2], b[4*w+3]};
    return r;
  endfunction

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [7:0] b);
    data_in = b;
    go = 1'b1;
    cyc(HOLD);
    go = 1'b0;
    cyc(HOLD);
  endtask

  task automatic load_all();
    for (int i = 0; i < 24; i++) press(bytes[i]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int vc0, uc0, n;
    logic [7:0] tgt;

    resetn = 1'b0; go = 1'b0; abort = 1'b0; out_ready = 1'b1; data_in = 8'h00;
    #1;
    check("rst_ops", ops_now, '0);
    check("rst_ctl", 192'({out_valid, word_idx, byte_idx}), '0);
    #12 resetn = 1'b1;
    cyc(2);

    // Sequential bytes with out_ready permanently high.
    for (int i = 0; i < 24; i++) bytes[i] = 8'(i + 1);
    vc0 = valid_cycles;
    load_all();
    check("t1_v0", 192'(v0), 192'(32'h01020304));
    check("t1_ops", ops_now, model(bytes));
    check("t1_valid_cycles", 192'(valid_cycles - vc0), 192'(1));
    check("t1_ctl", 192'({out_valid, word_idx, byte_idx}), '0);

    // Random bytes, downstream stalls, extra presses ignored while presenting.
    out_ready = 1'b0;
    for (int i = 0; i < 24; i++) bytes[i] = 8'($urandom);
    load_all();
    check("t2_valid", 192'(out_valid), 192'(1));
    uc0 = unstable_cnt;
    cyc(10);
    check("t2_valid_held", 192'(out_valid), 192'(1));
    check("t2_ops", ops_now, model(bytes));
    press(8'hFF);
    press(8'hFF);
    check("t3_ops", ops_now, model(bytes));
    check("t3_idx", 192'({word_idx, byte_idx}), 192'({3'd5, 2'd3}));
    check("t3_valid", 192'(out_valid), 192'(1));
    out_ready = 1'b1;
    cyc(1);
    check("t2_handshake", 192'({out_valid, word_idx, byte_idx}), '0);
    check("t2_stable", 192'(unstable_cnt - uc0), '0);

    // Nine bytes overwrite the head of the previous load, then abort races a press.
    for (int i = 0; i < 9; i++) begin
      bytes[i] = 8'($urandom);
      press(bytes[i]);
    end
    check("t4_partial", ops_now, model(bytes));
    check("t4_partial_idx", 192'({word_idx, byte_idx}), 192'({3'd2, 2'd1}));
    data_in = 8'h5A;
    go = 1'b1;
    cyc(PDET);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    check("t4_abort_ops", ops_now, '0);
    check("t4_abort_ctl", 192'({out_valid, word_idx, byte_idx}), '0);
    go = 1'b0;
    cyc(HOLD);
    check("t4_no_capture", ops_now, '0);
    check("t4_idx_after", 192'({word_idx, byte_idx}), '0);

    // Asynchronous reset in the middle of a press after five bytes.
    for (int i = 0; i < 5; i++) press(8'($urandom));
    data_in = 8'($urandom);
    go = 1'b1;
    cyc(1);
    #2 resetn = 1'b0;
    #1;
    check("t5_async_ops", ops_now, '0);
    check("t5_async_ctl", 192'({out_valid, word_idx, byte_idx}), '0);
    go = 1'b0;
    cyc(HOLD);
    resetn = 1'b1;
    cyc(2);
    for (int i = 0; i < 24; i++) bytes[i] = 8'($urandom);
    vc0 = valid_cycles;
    load_all();
    check("t5_reload_ops", ops_now, model(bytes));
    check("t5_valid_cycles", 192'(valid_cycles - vc0), 192'(1));

`ifdef LOADER_DEBOUNCE_EN
    // Short glitches must not capture; a long press captures once, 10 cycles after go rises.
    for (int g = 0; g < 3; g++) begin
      go = 1'b1;
      cyc(3);
      go = 1'b0;
      cyc(6);
    end
    cyc(12);
    check("db_glitch_ops", ops_now, model(bytes));
    check("db_glitch_idx", 192'({word_idx, byte_idx}), '0);
    tgt = ~bytes[0];
    data_in = tgt;
    go = 1'b1;
    n = 0;
    while (v0[31:24] !== tgt && n < 40) begin
      cyc(1);
      n++;
    end
    check("db_latency", 192'(n), 192'(PDET + 1));
    cyc(20 - n);
    go = 1'b0;
    cyc(HOLD);
    check("db_one_capture", 192'({word_idx, byte_idx}), 192'({3'd0, 2'd1}));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
